// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if: CPU, debug and RAM-side signals of the shared data-RAM port
interface ram_port_arbiter_if #(
   parameter int Width = 32,
   parameter int AddrWidth = 30
);
   logic                 cpuReq;
   logic                 cpuWrite;
   logic [AddrWidth-1:0] cpuAddr;
   logic [Width-1:0]     cpuWData;
   logic                 cpuStall;
   logic [Width-1:0]     cpuRData;
   logic                 cpuValid;
   logic                 dbgReq;
   logic                 dbgWrite;
   logic [AddrWidth-1:0] dbgAddr;
   logic [Width-1:0]     dbgWData;
   logic                 dbgGnt;
   logic [Width-1:0]     dbgRData;
   logic                 dbgValid;
   logic                 ramRead;
   logic                 ramWrite;
   logic [AddrWidth-1:0] ramAddr;
   logic [Width-1:0]     ramWData;
   logic [Width-1:0]     ramRData;
   modport slave (
      input  cpuReq, cpuWrite, cpuAddr, cpuWData, dbgReq, dbgWrite, dbgAddr, dbgWData, ramRData,
      output cpuStall, cpuRData, cpuValid, dbgGnt, dbgRData, dbgValid, ramRead, ramWrite, ramAddr, ramWData
   );
   modport master (
      output cpuReq, cpuWrite, cpuAddr, cpuWData, dbgReq, dbgWrite, dbgAddr, dbgWData, ramRData,
      input  cpuStall, cpuRData, cpuValid, dbgGnt, dbgRData, dbgValid, ramRead, ramWrite, ramAddr, ramWData
   );
endinterface

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: arbitrates the data-RAM port between CPU and debug; define RAM_ARB_DBG_WRITE_EN to let debug writes reach the RAM
module ram_port_arbiter #(
   parameter int Width = 32,
   parameter int AddrWidth = 30,
   parameter int StarveLimit = 4
) (
   input logic clk,
   input logic resetN,
   ram_port_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, CPU_RD, DBG_RD} state_t;
   localparam logic [3:0] Limit = 4'(StarveLimit);
   state_t state_q, state_d;
   logic [3:0] starve_q, starve_d;
   logic [Width-1:0] cpu_rdata_q, cpu_rdata_d, dbg_rdata_q, dbg_rdata_d;
   logic idle, dbg_pick, cpu_pick, dbg_wr;
`ifdef RAM_ARB_DBG_WRITE_EN
   assign dbg_wr = bus.dbgWrite;
`else
   assign dbg_wr = 1'b0;
`endif
   always_ff @(posedge clk) begin
      if (!resetN) begin
         state_q     <= IDLE;
         starve_q    <= '0;
         cpu_rdata_q <= '0;
         dbg_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         starve_q    <= starve_d;
         cpu_rdata_q <= cpu_rdata_d;
         dbg_rdata_q <= dbg_rdata_d;
      end
   end
   always_comb begin
      idle         = resetN && state_q == IDLE;
      dbg_pick     = idle && bus.dbgReq && (starve_q == Limit || !bus.cpuReq);
      cpu_pick     = idle && bus.cpuReq && !dbg_pick;
      bus.cpuValid = resetN && state_q == CPU_RD;
      bus.dbgValid = resetN && state_q == DBG_RD;
      bus.cpuRData = bus.cpuValid ? bus.ramRData : (resetN ? cpu_rdata_q : '0);
      bus.dbgRData = bus.dbgValid ? bus.ramRData : (resetN ? dbg_rdata_q : '0);
      cpu_rdata_d  = bus.cpuRData;
      dbg_rdata_d  = bus.dbgRData;
      bus.dbgGnt   = dbg_pick;
      bus.ramRead  = (cpu_pick && !bus.cpuWrite) || (dbg_pick && !bus.dbgWrite);
      bus.ramWrite = (cpu_pick && bus.cpuWrite) || (dbg_pick && dbg_wr);
      bus.ramAddr  = dbg_pick ? bus.dbgAddr : (cpu_pick ? bus.cpuAddr : '0);
      bus.ramWData = dbg_pick ? bus.dbgWData : (cpu_pick ? bus.cpuWData : '0);
      bus.cpuStall = bus.cpuReq && !(cpu_pick && bus.cpuWrite) && !bus.cpuValid;
      state_d      = bus.ramRead ? (dbg_pick ? DBG_RD : CPU_RD) : IDLE;
      starve_d     = (!bus.dbgReq || dbg_pick) ? '0 : (starve_q == Limit ? starve_q : starve_q + 4'd1);
   end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed bench with a cycle-level reference model of the RAM port arbiter
module tb_ram_port_arbiter;
   localparam int W = 32;
   localparam int AW = 30;
   localparam int LIM = 4;
`ifdef RAM_ARB_DBG_WRITE_EN
   localparam bit DBGW_EN = 1'b1;
`else
   localparam bit DBGW_EN = 1'b0;
`endif
   localparam logic [31:0] EXP9 = DBGW_EN ? 32'h000000FF : 32'hA5A5A5A5;
   logic clk = 1'b0;
   logic resetN = 1'b0;
   int n_vec = 0;
   int n_err = 0;
   always #5 clk = ~clk;
   ram_port_arbiter_if #(.Width(W), .AddrWidth(AW)) bus();
   ram_port_arbiter #(.Width(W), .AddrWidth(AW), .StarveLimit(LIM)) dut (
      .clk(clk),
      .resetN(resetN),
      .bus(bus)
   );
   logic [W-1:0] mem [0:255] = '{default: '0};
   always @(posedge clk) begin
      if (bus.ramWrite) mem[bus.ramAddr[7:0]] <= bus.ramWData;
      if (bus.ramRead) bus.ramRData <= mem[bus.ramAddr[7:0]];
   end
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask
   // reference model: who owns an outstanding read, how long debug has waited, and a shadow memory
   int pend = 0;
   int waited = 0;
   logic [31:0] pend_data = '0;
   logic [31:0] cpu_hold = '0;
   logic [31:0] dbg_hold = '0;
   logic [31:0] ref_mem [0:255] = '{default: '0};
   always @(negedge clk) begin : model
      bit e_stall, e_cv, e_dv, e_gnt, e_rd, e_wr, dbg_go, cpu_go;
      logic [31:0] e_cr, e_dr, e_addr;
      e_stall = 0; e_cv = 0; e_dv = 0; e_gnt = 0; e_rd = 0; e_wr = 0;
      dbg_go = 0; cpu_go = 0; e_addr = '0;
      e_cr = cpu_hold; e_dr = dbg_hold;
      if (!resetN) begin
         e_stall = bus.cpuReq;
         e_cr = '0; e_dr = '0;
         pend = 0; waited = 0; cpu_hold = '0; dbg_hold = '0;
      end else if (pend != 0) begin
         e_cv = pend == 1;
         e_dv = pend == 2;
         if (e_cv) e_cr = pend_data;
         if (e_dv) e_dr = pend_data;
         e_stall = bus.cpuReq && !e_cv;
         cpu_hold = e_cr; dbg_hold = e_dr;
         pend = 0;
         waited = bus.dbgReq ? (waited + 1 > LIM ? LIM : waited + 1) : 0;
      end else begin
         dbg_go = bus.dbgReq && (waited >= LIM || !bus.cpuReq);
         cpu_go = bus.cpuReq && !dbg_go;
         e_gnt = dbg_go;
         if (dbg_go) begin
            e_addr = 32'(bus.dbgAddr);
            e_rd = !bus.dbgWrite;
            e_wr = bus.dbgWrite && DBGW_EN;
            if (e_wr) ref_mem[bus.dbgAddr[7:0]] = bus.dbgWData;
            if (e_rd) begin pend = 2; pend_data = ref_mem[bus.dbgAddr[7:0]]; end
         end else if (cpu_go) begin
            e_addr = 32'(bus.cpuAddr);
            e_rd = !bus.cpuWrite;
            e_wr = bus.cpuWrite;
            if (e_wr) ref_mem[bus.cpuAddr[7:0]] = bus.cpuWData;
            if (e_rd) begin pend = 1; pend_data = ref_mem[bus.cpuAddr[7:0]]; end
         end
         e_stall = bus.cpuReq && !(cpu_go && bus.cpuWrite);
         waited = (!bus.dbgReq || dbg_go) ? 0 : (waited + 1 > LIM ? LIM : waited + 1);
      end
      chk("m_cpuStall", 32'(bus.cpuStall), 32'(e_stall));
      chk("m_cpuValid", 32'(bus.cpuValid), 32'(e_cv));
      chk("m_dbgValid", 32'(bus.dbgValid), 32'(e_dv));
      chk("m_dbgGnt", 32'(bus.dbgGnt), 32'(e_gnt));
      chk("m_ramRead", 32'(bus.ramRead), 32'(e_rd));
      chk("m_ramWrite", 32'(bus.ramWrite), 32'(e_wr));
      chk("m_cpuRData", bus.cpuRData, e_cr);
      chk("m_dbgRData", bus.dbgRData, e_dr);
      if (e_rd || e_wr) chk("m_ramAddr", 32'(bus.ramAddr), e_addr);
      if (e_wr) chk("m_ramWData", bus.ramWData, dbg_go ? bus.dbgWData : bus.cpuWData);
   end
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic cpu_set(input bit req, input bit wr, input int a, input logic [31:0] d);
      bus.cpuReq = req; bus.cpuWrite = wr; bus.cpuAddr = AW'(a); bus.cpuWData = d;
   endtask
   task automatic dbg_set(input bit req, input bit wr, input int a, input logic [31:0] d);
      bus.dbgReq = req; bus.dbgWrite = wr; bus.dbgAddr = AW'(a); bus.dbgWData = d;
   endtask
   initial begin
      int k;
      cpu_set(1, 0, 0, '0);
      dbg_set(0, 0, 0, '0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_stall", 32'(bus.cpuStall), 1);
         chk("rst_quiet", {27'd0, bus.dbgGnt, bus.ramRead, bus.ramWrite, bus.cpuValid, bus.dbgValid}, 0);
      end
      step(); resetN = 1'b1; cpu_set(0, 0, 0, '0);
      step(); cpu_set(1, 1, 5, 32'hDEADBEEF);
      @(negedge clk);
      chk("st_write", {bus.ramWrite, bus.cpuStall}, 2'b10);
      chk("st_addr", 32'(bus.ramAddr), 5);
      step(); cpu_set(1, 0, 5, '0);
      @(negedge clk);
      chk("ld_issue", {bus.cpuStall, bus.ramRead}, 2'b11);
      step();
      @(negedge clk);
      chk("ld_valid", {bus.cpuValid, bus.cpuStall}, 2'b10);
      chk("ld_data", bus.cpuRData, 32'hDEADBEEF);
      step(); cpu_set(0, 0, 0, '0); dbg_set(1, 0, 5, '0);
      @(negedge clk);
      chk("dr_gnt", {bus.dbgGnt, bus.ramRead}, 2'b11);
      step(); dbg_set(0, 0, 0, '0);
      @(negedge clk);
      chk("dr_valid", 32'(bus.dbgValid), 1);
      chk("dr_data", bus.dbgRData, 32'hDEADBEEF);
      step(); cpu_set(1, 0, 5, '0); dbg_set(1, 0, 5, '0);
      k = 0;
      @(negedge clk);
      while (!bus.dbgGnt && k < 20) begin
         step(); k++;
         @(negedge clk);
      end
      chk("starve_wait", k, 4);
      chk("starve_stall", 32'(bus.cpuStall), 1);
      step(); cpu_set(0, 0, 0, '0); dbg_set(0, 0, 0, '0);
      @(negedge clk);
      chk("starve_dvalid", 32'(bus.dbgValid), 1);
      step(); cpu_set(1, 1, 7, 32'h12345678); dbg_set(1, 0, 7, '0);
      @(negedge clk);
      chk("sim_cpu_first", {bus.ramWrite, bus.dbgGnt}, 2'b10);
      chk("sim_addr", 32'(bus.ramAddr), 7);
      step(); cpu_set(0, 0, 0, '0);
      @(negedge clk);
      chk("sim_dbg_gnt", 32'(bus.dbgGnt), 1);
      step(); dbg_set(0, 0, 0, '0);
      @(negedge clk);
      chk("sim_dbg_data", bus.dbgRData, 32'h12345678);
      step(); dbg_set(1, 0, 7, '0);
      @(negedge clk);
      chk("rr_gnt", 32'(bus.dbgGnt), 1);
      step(); dbg_set(0, 0, 0, '0); resetN = 1'b0;
      @(negedge clk);
      chk("rr_novalid", 32'(bus.dbgValid), 0);
      step(); resetN = 1'b1;
      @(negedge clk);
      chk("rr_after", {31'd0, bus.dbgValid}, 0);
      step(); cpu_set(1, 1, 9, 32'hA5A5A5A5);
      step(); cpu_set(0, 0, 0, '0); dbg_set(1, 1, 9, 32'h000000FF);
      @(negedge clk);
      chk("dw_gnt", 32'(bus.dbgGnt), 1);
      chk("dw_write", 32'(bus.ramWrite), 32'(DBGW_EN));
      step(); dbg_set(0, 0, 0, '0); cpu_set(1, 0, 9, '0);
      @(negedge clk);
      chk("dw_ld_stall", 32'(bus.cpuStall), 1);
      step();
      @(negedge clk);
      chk("dw_ld_data", bus.cpuRData, EXP9);
      step(); cpu_set(0, 0, 0, '0);
      for (int i = 0; i < 3; i++) step();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
   initial begin
      #100000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end
endmodule
